// File: rtl/ctrl_pkg.sv
// Shared definitions for the control unit: state encoding and state width,
// used by the FSM, the strobe decoder and any debug monitor.
package ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_ULA_OP    = 3'd3,
    S_ULA_WAIT  = 3'd4,
    S_STORE_RES = 3'd5,
    S_STORE_REG = 3'd6,
    S_HALT      = 3'd7
  } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decoder: Moore strobes from the current state, plus
// pc_increment which also needs rom_valid so it fires once per fetch.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_t state_i,
  input  logic   rom_valid_i,
  output logic   rom_read_o,
  output logic   pc_increment_o,
  output logic   gp_read_o,
  output logic   latch_ula_o,
  output logic   grab_ula_o,
  output logic   gp_write_o
);

  always_comb begin
    rom_read_o     = 1'b0;
    pc_increment_o = 1'b0;
    gp_read_o      = 1'b0;
    latch_ula_o    = 1'b0;
    grab_ula_o     = 1'b0;
    gp_write_o     = 1'b0;
    case (state_i)
      S_FETCH: begin
        rom_read_o     = 1'b1;
        pc_increment_o = rom_valid_i;
      end
      S_ULA_OP: begin
        gp_read_o   = 1'b1;
        latch_ula_o = 1'b1;
      end
      S_STORE_RES: grab_ula_o = 1'b1;
      S_STORE_REG: gp_write_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_unit.sv
// Processor control unit: sequences fetch, decode, ULA execution and
// write-back, with ROM wait, multi-cycle ULA ops, HALT and a retire counter.
module ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int                      OPCODE_W    = 4,
  parameter logic [OPCODE_W-1:0]     HALT_OPCODE = {OPCODE_W{1'b1}},
  parameter logic [2**OPCODE_W-1:0]  MULTI_MASK  = '0,
  parameter int                      ICOUNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                rom_valid,
  input  logic                ula_done,
  output logic [STATE_W-1:0]  state,
  output logic [OPCODE_W-1:0] ula_operation,
  output logic                rom_read,
  output logic                pc_increment,
  output logic                gp_read,
  output logic                latch_ula,
  output logic                grab_ula,
  output logic                gp_write,
  output logic                halted,
  output logic [ICOUNT_W-1:0] instr_count
);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [ICOUNT_W-1:0] count_q, count_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    count_d = count_q;
    case (state_q)
      S_IDLE:      if (run) state_d = S_FETCH;
      S_FETCH:     if (rom_valid) state_d = S_DECODE;
      S_DECODE: begin
        op_d    = opcode;
        state_d = (opcode == HALT_OPCODE) ? S_HALT : S_ULA_OP;
      end
      S_ULA_OP:    state_d = MULTI_MASK[op_q] ? S_ULA_WAIT : S_STORE_RES;
      S_ULA_WAIT:  if (ula_done) state_d = S_STORE_RES;
      S_STORE_RES: state_d = S_STORE_REG;
      S_STORE_REG: begin
        count_d = count_q + ICOUNT_W'(1);
        state_d = run ? S_FETCH : S_IDLE;
      end
      // HALT is absorbing; only reset leaves it
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      count_q <= count_d;
    end
  end

  ctrl_decode u_decode (
    .state_i        (state_q),
    .rom_valid_i    (rom_valid),
    .rom_read_o     (rom_read),
    .pc_increment_o (pc_increment),
    .gp_read_o      (gp_read),
    .latch_ula_o    (latch_ula),
    .grab_ula_o     (grab_ula),
    .gp_write_o     (gp_write)
  );

  assign state         = state_q;
  assign ula_operation = op_q;
  assign halted        = (state_q == S_HALT);
  assign instr_count   = count_q;

endmodule
